console_out: RTL and testbench



---
 rtl/console_out.sv | 166 ++++++++++++++++
 tb/tb_console_out.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_out.sv
// Memory-mapped console output: bus-written bytes queue in a 16-entry FIFO and drain on a ready/valid port.
// Optional low-watermark interrupt is built when CONSOLE_OUT_IRQ_EN is defined; otherwise irq is tied low.
module console_out #(
    parameter int FIFO_AW = 4,
    parameter int LOW_WM  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_cyc,
    input  logic        s_we,
    input  logic [3:0]  s_strb,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_data_i,
    output logic        s_ack,
    output logic [31:0] s_data_o,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LOW_WM_C = (FIFO_AW+1)'(LOW_WM);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic {ST_IDLE, ST_ACK} bus_state_e;

    bus_state_e         state_q, state_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               enable_q, enable_d;
    logic               irq_en_q, irq_en_d;
    logic [7:0]         mem_q [DEPTH];

    logic       commit;
    logic [1:0] reg_sel;
    logic       empty, full;
    logic       push_req, push_en, pop_en, flush;
    logic       ctrl_wr, status_wr;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: if (s_cyc) begin
                state_d = ST_ACK;
                commit  = 1'b1;
            end
            ST_ACK:  state_d = ST_IDLE;
        endcase
    end

    assign reg_sel   = s_addr[3:2];
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign ctrl_wr   = commit & s_we & (reg_sel == REG_CTRL);
    assign status_wr = commit & s_we & (reg_sel == REG_STATUS);
    assign flush     = ctrl_wr & s_data_i[1];
    assign push_req  = commit & s_we & (reg_sel == REG_DATA) & s_strb[0];
    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    assign push_en   = push_req & ~full & ~flush;
    assign pop_en    = tx_valid & tx_ready & ~flush;

    assign tx_valid = enable_q & ~empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign s_ack    = (state_q == ST_ACK);
    assign s_data_o = rdata_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_en && !pop_en)      count_d = count_q + CNT_ONE;
            else if (pop_en && !push_en) count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        ovf_d    = ovf_q;
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        if (push_req && full)
            ovf_d = 1'b1;
        else if (status_wr && s_data_i[10])
            ovf_d = 1'b0;
        if (ctrl_wr) begin
            enable_d = s_data_i[0];
            irq_en_d = s_data_i[2];
        end
    end

    // Read data reflects pre-edge state and is cleared outside the ack cycle.
    always_comb begin
        rdata_d = '0;
        if (commit && !s_we) begin
            case (reg_sel)
                REG_STATUS: begin
                    rdata_d[FIFO_AW:0] = count_q;
                    rdata_d[8]         = empty;
                    rdata_d[9]         = full;
                    rdata_d[10]        = ovf_q;
                end
                REG_CTRL: begin
                    rdata_d[0] = enable_q;
                    rdata_d[2] = irq_en_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rdata_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            if (push_en) mem_q[wr_ptr_q] <= s_data_i[7:0];
        end
    end

`ifdef CONSOLE_OUT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_en_q & enable_q & (count_q <= LOW_WM_C);
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{s_addr[31:4], s_addr[1:0], s_strb[3:1], s_data_i[31:11], s_data_i[9:8]};

endmodule

// File: tb/tb_console_out.sv
// Self-checking bench for console_out: directed scenarios followed by random bus/sink traffic,
// all checked each cycle against a queue-based model of the device.
module tb_console_out;

    logic        clk;
    logic        rst_n;
    logic        s_cyc;
    logic        s_we;
    logic [3:0]  s_strb;
    logic [31:0] s_addr;
    logic [31:0] s_data_i;
    logic        s_ack;
    logic [31:0] s_data_o;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    console_out #(.FIFO_AW(4), .LOW_WM(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_cyc(s_cyc), .s_we(s_we), .s_strb(s_strb),
        .s_addr(s_addr), .s_data_i(s_data_i), .s_ack(s_ack), .s_data_o(s_data_o),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [7:0]  q[$];
    bit          m_en, m_irqen, m_ovf, m_ack, m_irq, head_zero, live;
    logic [31:0] m_rdata;

    function automatic logic [31:0] status_val(int n, bit ovf);
        logic [31:0] v;
        v = 32'(n);
        if (n == 0)  v = v | 32'h100;
        if (n == 16) v = v | 32'h200;
        if (ovf)     v = v | 32'h400;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit irq_expect(bit lvl);
`ifdef CONSOLE_OUT_IRQ_EN
        return lvl;
`else
        return 1'b0 & lvl;
`endif
    endfunction

    // Check the current cycle against the model, advance the model over the next edge, then move to the next negedge.
    task automatic step();
        int          n;
        bit          valid, commit, irq_n;
        logic [31:0] rd_n;
        logic [1:0]  sel;
        n     = q.size();
        valid = m_en && (n > 0);
        if (live) begin
            chk("s_ack", {31'b0, s_ack}, {31'b0, m_ack});
            chk("s_data_o", s_data_o, m_rdata);
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, valid});
            if (valid)          chk("tx_data", {24'b0, tx_data}, {24'b0, q[0]});
            else if (head_zero) chk("tx_data_clr", {24'b0, tx_data}, 32'h0);
            chk("irq", {31'b0, irq}, {31'b0, irq_expect(m_irq)});
        end
        if (!rst_n) begin
            q.delete();
            m_en = 0; m_irqen = 0; m_ovf = 0; m_ack = 0; m_irq = 0;
            m_rdata = 32'h0; head_zero = 1; live = 1;
        end else begin
            sel    = s_addr[3:2];
            commit = !m_ack && s_cyc;
            irq_n  = m_irqen && m_en && (n <= 2);
            rd_n   = 32'h0;
            if (commit && !s_we) begin
                if (sel == 2'd1) rd_n = status_val(n, m_ovf);
                if (sel == 2'd2) rd_n = {29'b0, m_irqen, 1'b0, m_en};
            end
            if (valid && tx_ready) void'(q.pop_front());
            if (commit && s_we) begin
                if (sel == 2'd0 && s_strb[0]) begin
                    if (n == 16) m_ovf = 1;
                    else begin
                        q.push_back(s_data_i[7:0]);
                        head_zero = 0;
                    end
                end
                if (sel == 2'd1 && s_data_i[10]) m_ovf = 0;
                if (sel == 2'd2) begin
                    m_en    = s_data_i[0];
                    m_irqen = s_data_i[2];
                    if (s_data_i[1]) q.delete();
                end
            end
            m_ack   = commit;
            m_rdata = rd_n;
            m_irq   = irq_n;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus(input bit we, input logic [1:0] sel, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rd);
        logic [31:0] a;
        a        = $urandom;
        a[3:2]   = sel;
        s_cyc    = 1'b1;
        s_we     = we;
        s_addr   = a;
        s_data_i = data;
        s_strb   = strb;
        step();
        chk("bus_ack", {31'b0, s_ack}, 32'h1);
        rd       = s_data_o;
        s_cyc    = 1'b0;
        s_we     = 1'b0;
        s_strb   = 4'h0;
        s_data_i = $urandom;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  got[$];
        live = 0; head_zero = 1;
        rst_n = 1'b0; s_cyc = 1'b0; s_we = 1'b0; s_strb = 4'h0;
        s_addr = 32'h0; s_data_i = 32'h0; tx_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state and STATUS read
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("status_reset", rd, 32'h100);
        step();
        chk("data_o_idle", s_data_o, 32'h0);

        // Three bytes through an enabled FIFO
        bus(1'b1, 2'd2, 32'h1, 4'hF, rd);
        tx_ready = 1'b1;
        bus(1'b1, 2'd0, 32'h41, 4'h1, rd);
        bus(1'b1, 2'd0, 32'h42, 4'h1, rd);
        bus(1'b1, 2'd0, 32'h43, 4'h1, rd);
        step();
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("status_after_abc", rd, 32'h100);
        bus(1'b0, 2'd2, 32'h0, 4'hF, rd);
        chk("ctrl_read", rd, 32'h1);
        bus(1'b1, 2'd0, 32'h77, 4'h0, rd);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("strb0_no_push", rd, 32'h100);

        // Overflow with enable off
        tx_ready = 1'b0;
        bus(1'b1, 2'd2, 32'h0, 4'hF, rd);
        for (int i = 0; i <= 16; i++) bus(1'b1, 2'd0, 32'(i), 4'h1, rd);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("status_full_ovf", rd, 32'h610);
        bus(1'b1, 2'd2, 32'h1, 4'hF, rd);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) got.push_back(tx_data);
            step();
        end
        chk("drain_len", 32'(got.size()), 32'd16);
        if (got.size() == 16) chk("drain_last", {24'b0, got[15]}, 32'h0F);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("status_ovf_kept", rd, 32'h500);
        bus(1'b1, 2'd1, 32'h400, 4'hF, rd);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("status_ovf_clr", rd, 32'h100);

        // Sink stall
        tx_ready = 1'b0;
        bus(1'b1, 2'd0, 32'hA0, 4'h1, rd);
        bus(1'b1, 2'd0, 32'hA1, 4'h1, rd);
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {24'b0, tx_data}, 32'hA0);
            step();
        end
        bus(1'b1, 2'd0, 32'hA2, 4'h1, rd);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("stall_count3", rd, 32'h3);
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Flush while popping
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus(1'b1, 2'd0, 32'hB0 + 32'(i), 4'h1, rd);
        tx_ready = 1'b1;
        bus(1'b1, 2'd2, 32'h3, 4'hF, rd);
        chk("flush_valid", {31'b0, tx_valid}, 32'h0);
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("flush_status", rd, 32'h100);

        // Reset in the middle of a transfer
        tx_ready = 1'b0;
        bus(1'b1, 2'd0, 32'hC5, 4'h1, rd);
        s_cyc = 1'b1; s_we = 1'b1; s_addr = 32'h0; s_data_i = 32'hC6; s_strb = 4'h1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; s_cyc = 1'b0; s_we = 1'b0; s_strb = 4'h0;
        chk("midrst_ack", {31'b0, s_ack}, 32'h0);
        chk("midrst_data_o", s_data_o, 32'h0);
        chk("midrst_valid", {31'b0, tx_valid}, 32'h0);
        chk("midrst_tx_data", {24'b0, tx_data}, 32'h0);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        step();
        bus(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("midrst_status", rd, 32'h100);

        // Low-watermark interrupt
        bus(1'b1, 2'd2, 32'h5, 4'hF, rd);
        step();
        chk("irq_cnt0", {31'b0, irq}, {31'b0, irq_expect(1'b1)});
        for (int i = 1; i <= 4; i++) begin
            bus(1'b1, 2'd0, 32'hD0 + 32'(i), 4'h1, rd);
            step();
            chk("irq_level", {31'b0, irq}, {31'b0, irq_expect(i <= 2)});
        end
        bus(1'b1, 2'd2, 32'h7, 4'hF, rd);
        bus(1'b1, 2'd2, 32'h5, 4'hF, rd);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] d;
            tx_ready = ($urandom_range(0, 3) != 0);
            s_cyc    = $urandom_range(0, 1);
            s_we     = ($urandom_range(0, 3) != 0);
            s_addr   = $urandom;
            if ($urandom_range(0, 1) == 0) s_addr[3:2] = 2'd0;
            d        = $urandom;
            d[1]     = ($urandom_range(0, 15) == 0);
            d[0]     = ($urandom_range(0, 4) != 0);
            s_data_i = d;
            s_strb   = $urandom;
            step();
        end
        s_cyc = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
